// File: rtl/breakout_deser.sv
// Host-side deserializer for the breakout 3-wire link; fields and o_valid land 2 edges after the f9 pair is sampled.
// No backpressure: one frame every 5 cycles. BREAKOUT_DESER_ERR_CNT_EN enables the saturating bad-frame counter.
module breakout_deser #(
  parameter int LOCK_FRAMES = 2,
  parameter int MISS_LIMIT  = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_clk_s,
  input  logic [1:0]  i_d0_s,
  input  logic [1:0]  i_d1_s,
  output logic [7:0]  o_port,
  output logic [5:0]  o_button,
  output logic [3:0]  o_link_pow,
  output logic        o_valid,
  output logic        o_locked,
  output logic [15:0] o_frame_err_cnt
);

  localparam logic [9:0] CLK_PATTERN = 10'b1111100000;

  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [19:0] hist_c, hist_0, hist_1;
  logic        p_q, p_d;
  logic [2:0]  phase_q, phase_d;
  logic [3:0]  good_q, good_d;
  logic [3:0]  miss_q, miss_d;
  logic        locked_d;
  logic        cap;
  logic        err_inc;

  logic [9:0]  win_c, win_0, win_1;
  logic        match0, match1, match_sel, wrap;

  logic [7:0]  st_port;
  logic [5:0]  st_button;
  logic [3:0]  st_pow;
  logic        st_vld;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hist_c <= '0;
      hist_0 <= '0;
      hist_1 <= '0;
    end else begin
      hist_c <= {hist_c[17:0], i_clk_s[0], i_clk_s[1]};
      hist_0 <= {hist_0[17:0], i_d0_s[0], i_d0_s[1]};
      hist_1 <= {hist_1[17:0], i_d1_s[0], i_d1_s[1]};
    end
  end

  assign match0    = (hist_c[9:0]  == CLK_PATTERN);
  assign match1    = (hist_c[10:1] == CLK_PATTERN);
  assign win_c     = p_q ? hist_c[10:1] : hist_c[9:0];
  assign win_0     = p_q ? hist_0[10:1] : hist_0[9:0];
  assign win_1     = p_q ? hist_1[10:1] : hist_1[9:0];
  assign match_sel = (win_c == CLK_PATTERN);
  assign wrap      = (phase_q == 3'd4);

  // Older history bits and lane-0 f0/f1 carry nothing we decode.
  logic unused_bits;
  assign unused_bits = ^{hist_c[19:11], hist_0[19:11], hist_1[19:11], win_0[9:8]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= HUNT;
      p_q      <= 1'b0;
      phase_q  <= '0;
      good_q   <= '0;
      miss_q   <= '0;
      o_locked <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      phase_q  <= phase_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      o_locked <= locked_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    phase_d  = wrap ? 3'd0 : phase_q + 3'd1;
    good_d   = good_q;
    miss_d   = miss_q;
    locked_d = o_locked;
    cap      = 1'b0;
    err_inc  = 1'b0;
    case (state_q)
      HUNT: begin
        if (match0 || match1) begin
          p_d     = !match0;
          phase_d = 3'd0;
          good_d  = 4'd1;
          miss_d  = 4'd0;
          state_d = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (wrap) begin
          if (match_sel) begin
            good_d = good_q + 4'd1;
            if (int'(good_q) + 1 >= LOCK_FRAMES) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = 4'd0;
            end
          end else begin
            state_d = HUNT;
            err_inc = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (wrap) begin
          if (match_sel) begin
            cap    = 1'b1;
            miss_d = 4'd0;
          end else begin
            miss_d  = miss_q + 4'd1;
            err_inc = 1'b1;
            if (int'(miss_q) + 1 >= MISS_LIMIT) begin
              state_d  = HUNT;
              locked_d = 1'b0;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Two-stage output path: capture the window, then publish on the next edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_vld     <= 1'b0;
      st_port    <= '0;
      st_button  <= '0;
      st_pow     <= '0;
      o_valid    <= 1'b0;
      o_port     <= '0;
      o_button   <= '0;
      o_link_pow <= '0;
    end else begin
      st_vld  <= cap;
      o_valid <= st_vld;
      if (cap) begin
        st_port   <= win_1[9:2];
        st_button <= win_0[7:2];
        st_pow    <= {win_1[0], win_1[1], win_0[0], win_0[1]};
      end
      if (st_vld) begin
        o_port     <= st_port;
        o_button   <= st_button;
        o_link_pow <= st_pow;
      end
    end
  end

`ifdef BREAKOUT_DESER_ERR_CNT_EN
  logic [15:0] err_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= '0;
    end else if (err_inc && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign o_frame_err_cnt = err_q;
`else
  logic unused_err;
  assign unused_err      = err_inc;
  assign o_frame_err_cnt = '0;
`endif

endmodule

// File: tb/tb_breakout_deser.sv
// Directed bench for breakout_deser: per-frame table rows plus reset and offset-1 sequences.
module tb_breakout_deser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  clk_s = '0, d0_s = '0, d1_s = '0;
  logic [7:0]  port;
  logic [5:0]  button;
  logic [3:0]  link_pow;
  logic        valid, locked;
  logic [15:0] err_cnt;

  breakout_deser dut (
    .i_clk(clk), .i_rst(rst), .i_clk_s(clk_s), .i_d0_s(d0_s), .i_d1_s(d1_s),
    .o_port(port), .o_button(button), .o_link_pow(link_pow),
    .o_valid(valid), .o_locked(locked), .o_frame_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // One row = one frame slot of 5 cycles. Expected values describe what is
  // seen by the end of that slot, i.e. the decode of the previous frame.
  typedef struct {
    logic [7:0] port;
    logic [5:0] button;
    logic [3:0] pow;
    bit         bad;
    int         exp_nvld;
    logic       exp_locked;
    logic [7:0] exp_port;
    logic [5:0] exp_button;
    logic [3:0] exp_pow;
    int         exp_err;
  } vec_t;

  bit qc[$], q0[$], q1[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic [7:0] p, input logic [5:0] b, input logic [3:0] w, input bit bad,
                              input int nv, input logic lk, input logic [7:0] ep, input logic [5:0] eb,
                              input logic [3:0] ew, input int ee);
    vec_t v;
    v.port = p; v.button = b; v.pow = w; v.bad = bad;
    v.exp_nvld = nv; v.exp_locked = lk; v.exp_port = ep; v.exp_button = eb; v.exp_pow = ew; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bit index 9 of each vector is f0, sent first.
  task automatic push_frame(input logic [7:0] p, input logic [5:0] b, input logic [3:0] w, input bit bad);
    logic [9:0] fc, f0, f1;
    fc = bad ? 10'b1111110000 : 10'b1111100000;
    f0 = {2'b00, b, w[0], w[1]};
    f1 = {p, w[2], w[3]};
    for (int i = 9; i >= 0; i--) begin
      qc.push_back(fc[i]);
      q0.push_back(f0[i]);
      q1.push_back(f1[i]);
    end
  endtask

  task automatic drive_cycle();
    bit ca, cb, a0, b0, a1, b1;
    ca = 0; cb = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    @(negedge clk);
    if (qc.size() > 0) ca = qc.pop_front();
    if (qc.size() > 0) cb = qc.pop_front();
    if (q0.size() > 0) a0 = q0.pop_front();
    if (q0.size() > 0) b0 = q0.pop_front();
    if (q1.size() > 0) a1 = q1.pop_front();
    if (q1.size() > 0) b1 = q1.pop_front();
    clk_s = {cb, ca};
    d0_s  = {b0, a0};
    d1_s  = {b1, a1};
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input vec_t v, input string tag);
    int nv;
    int ee;
    nv = 0;
    push_frame(v.port, v.button, v.pow, v.bad);
    for (int c = 0; c < 5; c++) begin
      drive_cycle();
      if (valid) nv++;
    end
`ifdef BREAKOUT_DESER_ERR_CNT_EN
    ee = v.exp_err;
`else
    ee = 0;
`endif
    chk({tag, ".valid_count"}, nv, v.exp_nvld);
    chk({tag, ".locked"}, {31'd0, locked}, {31'd0, v.exp_locked});
    chk({tag, ".port"}, {24'd0, port}, {24'd0, v.exp_port});
    chk({tag, ".button"}, {26'd0, button}, {26'd0, v.exp_button});
    chk({tag, ".link_pow"}, {28'd0, link_pow}, {28'd0, v.exp_pow});
    chk({tag, ".err_cnt"}, {16'd0, err_cnt}, ee);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, valid}, 0);
    chk({tag, ".locked"}, {31'd0, locked}, 0);
    chk({tag, ".port"}, {24'd0, port}, 0);
    chk({tag, ".button"}, {26'd0, button}, 0);
    chk({tag, ".link_pow"}, {28'd0, link_pow}, 0);
    chk({tag, ".err_cnt"}, {16'd0, err_cnt}, 0);
  endtask

  vec_t t1[16];
  vec_t t2[4];
  vec_t t3[4];

  initial begin
    // A = A5/2C/9, B = 5A/13/6, corrupt frames carry zero data.
    t1[0]  = mk(8'hA5, 6'h2C, 4'h9, 0, 0, 0, 8'h00, 6'h00, 4'h0, 0);
    t1[1]  = mk(8'hA5, 6'h2C, 4'h9, 0, 0, 0, 8'h00, 6'h00, 4'h0, 0);
    t1[2]  = mk(8'hA5, 6'h2C, 4'h9, 0, 0, 1, 8'h00, 6'h00, 4'h0, 0);
    t1[3]  = mk(8'hA5, 6'h2C, 4'h9, 0, 1, 1, 8'hA5, 6'h2C, 4'h9, 0);
    t1[4]  = mk(8'hA5, 6'h2C, 4'h9, 0, 1, 1, 8'hA5, 6'h2C, 4'h9, 0);
    t1[5]  = mk(8'h00, 6'h00, 4'h0, 1, 1, 1, 8'hA5, 6'h2C, 4'h9, 0);
    t1[6]  = mk(8'h00, 6'h00, 4'h0, 1, 0, 1, 8'hA5, 6'h2C, 4'h9, 1);
    t1[7]  = mk(8'h5A, 6'h13, 4'h6, 0, 0, 1, 8'hA5, 6'h2C, 4'h9, 2);
    t1[8]  = mk(8'h5A, 6'h13, 4'h6, 0, 1, 1, 8'h5A, 6'h13, 4'h6, 2);
    t1[9]  = mk(8'h00, 6'h00, 4'h0, 1, 1, 1, 8'h5A, 6'h13, 4'h6, 2);
    t1[10] = mk(8'h00, 6'h00, 4'h0, 1, 0, 1, 8'h5A, 6'h13, 4'h6, 3);
    t1[11] = mk(8'h00, 6'h00, 4'h0, 1, 0, 1, 8'h5A, 6'h13, 4'h6, 4);
    t1[12] = mk(8'hA5, 6'h2C, 4'h9, 0, 0, 0, 8'h5A, 6'h13, 4'h6, 5);
    t1[13] = mk(8'hA5, 6'h2C, 4'h9, 0, 0, 0, 8'h5A, 6'h13, 4'h6, 5);
    t1[14] = mk(8'hA5, 6'h2C, 4'h9, 0, 0, 1, 8'h5A, 6'h13, 4'h6, 5);
    t1[15] = mk(8'hA5, 6'h2C, 4'h9, 0, 1, 1, 8'hA5, 6'h2C, 4'h9, 5);

    t2[0] = mk(8'hA5, 6'h2C, 4'h9, 0, 0, 0, 8'h00, 6'h00, 4'h0, 0);
    t2[1] = mk(8'hA5, 6'h2C, 4'h9, 0, 0, 0, 8'h00, 6'h00, 4'h0, 0);
    t2[2] = mk(8'hA5, 6'h2C, 4'h9, 0, 0, 1, 8'h00, 6'h00, 4'h0, 0);
    t2[3] = mk(8'hA5, 6'h2C, 4'h9, 0, 1, 1, 8'hA5, 6'h2C, 4'h9, 0);

    t3[0] = mk(8'h3C, 6'h15, 4'h5, 0, 0, 0, 8'h00, 6'h00, 4'h0, 0);
    t3[1] = mk(8'h3C, 6'h15, 4'h5, 0, 0, 0, 8'h00, 6'h00, 4'h0, 0);
    t3[2] = mk(8'h3C, 6'h15, 4'h5, 0, 0, 1, 8'h00, 6'h00, 4'h0, 0);
    t3[3] = mk(8'h3C, 6'h15, 4'h5, 0, 1, 1, 8'h3C, 6'h15, 4'h5, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_row(t1[i], $sformatf("aligned[%0d]", i));

    // Reset lands mid-frame, one cycle into the o_valid pulse of the last good frame.
    push_frame(8'hA5, 6'h2C, 4'h9, 0);
    drive_cycle();
    drive_cycle();
    chk("mid_rst.pre_valid", {31'd0, valid}, 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    qc.delete();
    q0.delete();
    q1.delete();
    drive_cycle();
    drive_cycle();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) run_row(t2[i], $sformatf("relock[%0d]", i));

    // Offset-1 stream: one leading filler bit on every lane.
    @(negedge clk);
    rst = 1'b1;
    drive_cycle();
    drive_cycle();
    @(negedge clk);
    rst = 1'b0;
    qc.push_back(1'b0);
    q0.push_back(1'b0);
    q1.push_back(1'b0);
    for (int i = 0; i < 4; i++) run_row(t3[i], $sformatf("offset1[%0d]", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
